// File: rtl/tri_raster_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tri_raster_ctrl_pkg
// Shared types and constants for the triangle command scheduler.
//   - screen geometry defaults
//   - vertex (packed {y, x}, signed 28.4) and RGB565 colour typedefs
//   - packed command record stored in the command FIFO
//   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package tri_raster_ctrl_pkg;

    localparam int unsigned SCREEN_WIDTH_DEFAULT  = 640;
    localparam int unsigned SCREEN_HEIGHT_DEFAULT = 480;

    // One vertex: y in the upper word, x in the lower word, both signed 28.4.
    typedef struct packed {
        logic signed [31:0] y;
        logic signed [31:0] x;
    } vertex_t;

    typedef logic [15:0] color_t;

    // One queued triangle command (3 x 64 + 16 bits).
    typedef struct packed {
        vertex_t v1;
        vertex_t v2;
        vertex_t v3;
        color_t  color;
    } tri_cmd_t;

    localparam int unsigned TRI_CMD_W = $bits(tri_cmd_t);

    // Scheduler FSM encoding.
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    // Cycles spent in ACK with done still high before the start pulse is repeated.
    localparam int unsigned ACK_RETRY_CYCLES = 4;

endpackage

// File: rtl/tri_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tri_cmd_fifo
// Synchronous FIFO for triangle commands, show-ahead (head is the oldest entry).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data write request and data; ignored when full
//   pop             read request; ignored when empty
//   head            oldest entry, valid while !empty
//   full, empty     occupancy flags, combinational from the pointers
// -----------------------------------------------------------------------------
module tri_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    // Storage is not reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tri_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tri_raster_ctrl
// Triangle command scheduler in front of a point-emitting rasterizer. Commands
// are queued in a small FIFO, launched one at a time, and each emitted point is
// turned into a linear framebuffer write carrying the triangle's colour.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_tri_valid, o_tri_ready  command handshake (ready = FIFO not full)
//   i_tri_v1..3, i_tri_color  command payload: {y, x} 28.4 vertices, RGB565
//   o_rast_start              one-cycle launch pulse to the rasterizer
//   o_rast_v1..3              vertices of the current triangle
//   i_rast_write, i_rast_point, i_rast_done   rasterizer point stream / idle
//   o_px_we, o_px_addr, o_px_color            framebuffer write port
//   o_busy                    work queued or a triangle in flight
//   o_tri_count               completed triangles, wraps at 2^16
// -----------------------------------------------------------------------------
module tri_raster_ctrl
    import tri_raster_ctrl_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEFAULT,
    parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEFAULT,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned ADDR_W        = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // command port
    input  logic              i_tri_valid,
    output logic              o_tri_ready,
    input  logic [63:0]       i_tri_v1,
    input  logic [63:0]       i_tri_v2,
    input  logic [63:0]       i_tri_v3,
    input  logic [15:0]       i_tri_color,
    // rasterizer port
    output logic              o_rast_start,
    output logic [63:0]       o_rast_v1,
    output logic [63:0]       o_rast_v2,
    output logic [63:0]       o_rast_v3,
    input  logic              i_rast_write,
    input  logic [31:0]       i_rast_point,
    input  logic              i_rast_done,
    // framebuffer port
    output logic              o_px_we,
    output logic [ADDR_W-1:0] o_px_addr,
    output logic [15:0]       o_px_color,
    // status
    output logic              o_busy,
    output logic [15:0]       o_tri_count
);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    tri_cmd_t          push_cmd;
    tri_cmd_t          head_cmd;
    logic [TRI_CMD_W-1:0] head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign push_cmd = {i_tri_v1, i_tri_v2, i_tri_v3, i_tri_color};
    assign head_cmd = tri_cmd_t'(head_bits);

    tri_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRI_CMD_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (i_tri_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_tri_ready = !fifo_full;

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [1:0]  ack_cnt_q;
    logic [1:0]  ack_cnt_d;
    logic        start_q;
    logic        start_d;
    logic        count_inc;
    logic [15:0] tri_count_q;

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        start_d   = 1'b0;
        pop       = 1'b0;
        count_inc = 1'b0;
        case (state_q)
            // The rasterizer has no reset; let it finish whatever it was doing.
            ST_SYNC: begin
                if (i_rast_done) begin
                    state_d = ST_IDLE;
                end
            end
            // Launch only once done has been seen high here, so the final point
            // of the previous triangle has already picked up the old colour.
            ST_IDLE: begin
                if (!fifo_empty && i_rast_done) begin
                    pop       = 1'b1;
                    start_d   = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!i_rast_done) begin
                    ack_cnt_d = '0;
                    state_d   = ST_RUN;
                end else if (ack_cnt_q == 2'(ACK_RETRY_CYCLES - 1)) begin
                    // Start appears to have been missed; pulse it again.
                    start_d   = 1'b1;
                    ack_cnt_d = '0;
                end else begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                end
            end
            ST_RUN: begin
                if (i_rast_done) begin
                    count_inc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Point to framebuffer write
    // ------------------------------------------------------------------
    logic [15:0]       pt_x;
    logic [15:0]       pt_y;
    logic              pt_in_range;
    logic              px_accept;
    logic [ADDR_W-1:0] px_addr_d;

    assign pt_x        = i_rast_point[15:0];
    assign pt_y        = i_rast_point[31:16];
    assign pt_in_range = (32'(pt_x) < SCREEN_WIDTH) && (32'(pt_y) < SCREEN_HEIGHT);
    // Points are discarded while resynchronising after reset.
    assign px_accept   = i_rast_write && pt_in_range && (state_q != ST_SYNC);
    assign px_addr_d   = ADDR_W'(pt_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(pt_x);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    vertex_t v1_q;
    vertex_t v2_q;
    vertex_t v3_q;
    color_t  color_q;
    logic              px_we_q;
    logic [ADDR_W-1:0] px_addr_q;
    color_t            px_color_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_SYNC;
            ack_cnt_q   <= '0;
            start_q     <= 1'b0;
            v1_q        <= '0;
            v2_q        <= '0;
            v3_q        <= '0;
            color_q     <= '0;
            tri_count_q <= '0;
            px_we_q     <= 1'b0;
            px_addr_q   <= '0;
            px_color_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            start_q   <= start_d;
            // Vertices and colour change only on a pop and hold until the next.
            if (pop) begin
                v1_q    <= head_cmd.v1;
                v2_q    <= head_cmd.v2;
                v3_q    <= head_cmd.v3;
                color_q <= head_cmd.color;
            end
            if (count_inc) begin
                tri_count_q <= tri_count_q + 16'd1;
            end
            px_we_q <= px_accept;
            if (px_accept) begin
                px_addr_q  <= px_addr_d;
                px_color_q <= color_q;
            end
        end
    end

    assign o_rast_start = start_q;
    assign o_rast_v1    = v1_q;
    assign o_rast_v2    = v2_q;
    assign o_rast_v3    = v3_q;
    assign o_px_we      = px_we_q;
    assign o_px_addr    = px_addr_q;
    assign o_px_color   = px_color_q;
    assign o_tri_count  = tri_count_q;
    // SYNC is not counted as busy: nothing of ours is in flight there.
    assign o_busy       = !fifo_empty || (state_q == ST_ACK) || (state_q == ST_RUN);

endmodule

// File: tb/tb_tri_raster_ctrl.sv
`timescale 1ns/1ps
module tb_tri_raster_ctrl;

    localparam int unsigned W      = 640;
    localparam int unsigned H      = 480;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              tri_valid;
    logic              tri_ready;
    logic [63:0]       tri_v1, tri_v2, tri_v3;
    logic [15:0]       tri_color;
    logic              rast_start;
    logic [63:0]       rast_v1, rast_v2, rast_v3;
    logic              rast_write;
    logic [31:0]       rast_point;
    logic              rast_done;
    logic              px_we;
    logic [ADDR_W-1:0] px_addr;
    logic [15:0]       px_color;
    logic              busy;
    logic [15:0]       tri_count;

    tri_raster_ctrl #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tri_valid  (tri_valid),
        .o_tri_ready  (tri_ready),
        .i_tri_v1     (tri_v1),
        .i_tri_v2     (tri_v2),
        .i_tri_v3     (tri_v3),
        .i_tri_color  (tri_color),
        .o_rast_start (rast_start),
        .o_rast_v1    (rast_v1),
        .o_rast_v2    (rast_v2),
        .o_rast_v3    (rast_v3),
        .i_rast_write (rast_write),
        .i_rast_point (rast_point),
        .i_rast_done  (rast_done),
        .o_px_we      (px_we),
        .o_px_addr    (px_addr),
        .o_px_color   (px_color),
        .o_busy       (busy),
        .o_tri_count  (tri_count)
    );

    typedef struct packed {
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] v3;
        logic [15:0] color;
    } cmd_t;

    // Bench bookkeeping
    int n_checks = 0;
    int n_errors = 0;
    cmd_t to_send[$];      // commands still to be offered
    cmd_t fifo_model[$];   // accepted, not yet launched
    cmd_t cur_cmd;
    logic [15:0] cur_color = '0;
    bit   discard   = 1'b1; // controller is resynchronising: no starts, no pixels
    bit   inflight  = 1'b0; // launched, completion not yet seen
    bit   awaiting  = 1'b0; // launched, rasterizer has not accepted yet
    bit   counting  = 1'b0; // rasterizer busy on a triangle that will count
    bit   r_active  = 1'b0;
    bit   ignore_next = 1'b0;
    int   acc_wait  = -1;
    int   pts_left  = 0;
    int   boot_wait = 6;
    int   force_pts = 0;
    int   emit_pct  = 70;
    int   valid_pct = 100;
    int   exp_count = 0;
    int   n_launch  = 0;
    int   n_repulse = 0;
    int   n_px      = 0;
    int   cyc       = 0;
    int   push_cyc  = 0;
    int   launch_lat = 0;
    logic [ADDR_W-1:0] last_px_addr = '0;
    logic [31:0] dir_pts[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.v1    = {$urandom, $urandom};
        c.v2    = {$urandom, $urandom};
        c.v3    = {$urandom, $urandom};
        c.color = 16'($urandom);
        return c;
    endfunction

    // One clock: capture what the DUT sees at the edge, advance the reference
    // model, compare, then drive the next inputs (command source + rasterizer).
    task automatic cycle();
        bit          p_push, p_write, p_done, p_disc, p_cnt, p_rst, exp_we;
        logic [31:0] p_pt;
        cmd_t        p_cmd;
        int          px, py, a;
        p_rst   = rst_n;
        p_push  = rst_n && tri_valid && tri_ready;
        p_cmd   = {tri_v1, tri_v2, tri_v3, tri_color};
        p_write = rast_write;
        p_pt    = rast_point;
        p_done  = rast_done;
        p_disc  = discard;
        p_cnt   = counting;
        @(posedge clk);
        #1;
        cyc++;
        if (p_push) begin
            fifo_model.push_back(p_cmd);
            to_send.delete(0);
            push_cyc = cyc;
        end
        // pixel stream, one cycle behind the point
        px = int'(p_pt[15:0]);
        py = int'(p_pt[31:16]);
        exp_we = p_write && !p_disc && (px < W) && (py < H);
        check_eq("px_we", px_we, exp_we);
        if (exp_we && px_we) begin
            a = (py * W + px) & ((1 << ADDR_W) - 1);
            check_eq("px_addr", px_addr, 64'(a));
            check_eq("px_color", px_color, cur_color);
        end
        if (px_we) begin
            n_px++;
            last_px_addr = px_addr;
        end
        // completion / resync
        if (p_rst && p_done && p_cnt) begin
            exp_count = (exp_count + 1) % 65536;
            inflight  = 1'b0;
            counting  = 1'b0;
        end
        if (p_rst && p_done && p_disc) discard = 1'b0;
        check_eq("tri_count", tri_count, 64'(exp_count));
        // launches
        if (rast_start) begin
            if (discard || (!awaiting && fifo_model.size() == 0)) begin
                check_eq("start_unexpected", rast_start, 1'b0);
            end else begin
                if (!awaiting) begin
                    cur_cmd    = fifo_model.pop_front();
                    cur_color  = cur_cmd.color;
                    awaiting   = 1'b1;
                    inflight   = 1'b1;
                    launch_lat = cyc - push_cyc;
                    n_launch++;
                end else begin
                    n_repulse++;
                end
                check_eq("rast_v1", rast_v1, cur_cmd.v1);
                check_eq("rast_v2", rast_v2, cur_cmd.v2);
                check_eq("rast_v3", rast_v3, cur_cmd.v3);
                if (ignore_next) ignore_next = 1'b0;
                else if (!r_active && acc_wait < 0) acc_wait = int'($urandom_range(0, 2));
            end
        end
        check_eq("tri_ready", tri_ready, fifo_model.size() < DEPTH);
        check_eq("busy", busy, (fifo_model.size() != 0) || inflight);
        // behavioural rasterizer
        rast_write = 1'b0;
        rast_point = $urandom;
        if (boot_wait > 0) begin
            boot_wait--;
            if (boot_wait == 0) rast_done = 1'b1;
        end else if (acc_wait == 0) begin
            acc_wait  = -1;
            rast_done = 1'b0;
            r_active  = 1'b1;
            counting  = 1'b1;
            awaiting  = 1'b0;
            if (dir_pts.size() > 0) pts_left = dir_pts.size();
            else if (force_pts > 0) pts_left = force_pts;
            else pts_left = int'($urandom_range(3, 8));
        end else if (acc_wait > 0) begin
            acc_wait--;
        end else if (r_active && (dir_pts.size() > 0 || int'($urandom_range(0, 99)) < emit_pct)) begin
            rast_write = 1'b1;
            if (dir_pts.size() > 0) begin
                rast_point = dir_pts[0];
                dir_pts.delete(0);
            end else begin
                rast_point = {16'($urandom_range(0, H + 40)), 16'($urandom_range(0, W + 60))};
            end
            pts_left--;
            if (pts_left == 0) begin
                rast_done = 1'b1; // final point coincides with done
                r_active  = 1'b0;
            end
        end
        // command source
        if (rst_n && to_send.size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
            tri_valid = 1'b1;
            {tri_v1, tri_v2, tri_v3, tri_color} = to_send[0];
        end else begin
            tri_valid = 1'b0;
            {tri_v1, tri_v2, tri_v3, tri_color} = {$urandom, $urandom, $urandom, $urandom,
                                                   $urandom, $urandom, 16'($urandom)};
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((to_send.size() != 0 || fifo_model.size() != 0 || inflight || r_active ||
                acc_wait >= 0 || discard) && n < 3000) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(n >= 3000), 64'd0);
        repeat (3) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, tri_ready, 1'b1);
        check_eq({tag, "_start"}, rast_start, 1'b0);
        check_eq({tag, "_px_we"}, px_we, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_v1"}, rast_v1, 64'd0);
        check_eq({tag, "_v2"}, rast_v2, 64'd0);
        check_eq({tag, "_v3"}, rast_v3, 64'd0);
        check_eq({tag, "_addr"}, px_addr, 64'd0);
        check_eq({tag, "_color"}, px_color, 64'd0);
        check_eq({tag, "_count"}, tri_count, 64'd0);
    endtask

    initial begin
        int base_launch, base_px, base_rep, base_cnt, n;
        cmd_t c;
        tri_valid  = 1'b0;
        tri_v1     = '0;
        tri_v2     = '0;
        tri_v3     = '0;
        tri_color  = '0;
        rast_write = 1'b0;
        rast_point = '0;
        rast_done  = 1'b0; // rasterizer still busy from before power-up
        #3;
        check_reset_outputs("reset");
        repeat (2) cycle();
        rst_n = 1'b1;
        wait_idle("boot");

        // Single triangle (0,0),(160,0),(0,160), red
        base_launch = n_launch;
        c.v1 = 64'd0;
        c.v2 = {32'd0, 32'd2560};
        c.v3 = {32'd2560, 32'd0};
        c.color = 16'hF800;
        to_send.push_back(c);
        wait_idle("drain_single");
        check_eq("single_launches", 64'(n_launch - base_launch), 64'd1);
        check_eq("single_latency", 64'(launch_lat), 64'd1);
        check_eq("single_count", tri_count, 64'd1);
        check_eq("single_busy", busy, 1'b0);

        // Five back-to-back pushes
        base_launch = n_launch;
        base_cnt    = exp_count;
        for (int i = 0; i < 5; i++) to_send.push_back(rand_cmd());
        n = 0;
        while (to_send.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check_eq("five_ready_low", tri_ready, 1'b0);
        wait_idle("drain_five");
        check_eq("five_launches", 64'(n_launch - base_launch), 64'd5);
        check_eq("five_count", tri_count, 64'((base_cnt + 5) % 65536));

        // Clipping: two off-screen points, one on the last pixel
        base_px = n_px;
        dir_pts.push_back({16'd10, 16'd640});
        dir_pts.push_back({16'd480, 16'd5});
        dir_pts.push_back({16'd479, 16'd639});
        to_send.push_back(rand_cmd());
        wait_idle("drain_clip");
        check_eq("clip_px_count", 64'(n_px - base_px), 64'd1);
        check_eq("clip_last_addr", last_px_addr, 64'd307199);

        // Rasterizer misses the first start pulse
        base_rep = n_repulse;
        ignore_next = 1'b1;
        to_send.push_back(rand_cmd());
        wait_idle("drain_retry");
        check_eq("retry_pulses", 64'(n_repulse - base_rep), 64'd1);

        // Randomized traffic
        base_rep = n_repulse;
        for (int i = 0; i < 24; i++) to_send.push_back(rand_cmd());
        for (int i = 0; i < 8; i++) begin
            valid_pct = int'($urandom_range(30, 100));
            emit_pct  = int'($urandom_range(30, 100));
            repeat (40) cycle();
        end
        valid_pct = 100;
        emit_pct  = 70;
        wait_idle("drain_random");
        check_eq("random_no_retry", 64'(n_repulse - base_rep), 64'd0);

        // Reset in the middle of a running triangle with two entries queued
        force_pts = 30;
        emit_pct  = 40;
        for (int i = 0; i < 3; i++) to_send.push_back(rand_cmd());
        n = 0;
        while (!(r_active && inflight && fifo_model.size() == 2) && n < 500) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        fifo_model.delete();
        to_send.delete();
        discard     = 1'b1;
        inflight    = 1'b0;
        awaiting    = 1'b0;
        counting    = 1'b0;
        acc_wait    = -1;
        ignore_next = 1'b0;
        exp_count   = 0;
        force_pts   = 0;
        tri_valid   = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("post_reset_ready", tri_ready, 1'b1);
        check_eq("post_reset_count", tri_count, 64'd0);
        // Queue a command while still resynchronising; it must wait for done.
        base_launch = n_launch;
        to_send.push_back(rand_cmd());
        wait_idle("drain_post_reset");
        check_eq("post_reset_launches", 64'(n_launch - base_launch), 64'd1);
        check_eq("post_reset_count_final", tri_count, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
